// File: rtl/branch_pkg.sv
// Shared definitions for the RV32I branch resolution unit: funct3 condition codes and default width.
package branch_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: decides taken for a funct3 code and flags reserved codes.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal_f3
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    // NOTE: both outputs get defaults first so no path through the case infers a latch.
    always_comb begin
        taken      = 1'b0;
        illegal_f3 = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: illegal_f3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch.sv
// Execute-stage branch resolution: registers taken decision, pc+imm target and fault flags one cycle later.
module branch
    import branch_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int IALIGN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            z_branch,
    output logic [XLEN-1:0] target,
    output logic            valid_o,
    output logic            illegal,
    output logic            misaligned
);

    logic            taken;
    logic            illegal_f3;
    logic [XLEN-1:0] sum;
    logic            addr_bad;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3     (funct3),
        .rs1        (rs1_data),
        .rs2        (rs2_data),
        .taken      (taken),
        .illegal_f3 (illegal_f3)
    );

    // Modulo-2^XLEN add; carry out is intentionally dropped.
    assign sum      = pc + imm;
    assign addr_bad = (IALIGN == 16) ? sum[0] : (sum[1:0] != 2'b00);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_branch   <= 1'b0;
            target     <= '0;
            valid_o    <= 1'b0;
            illegal    <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            valid_o    <= valid_i;
            z_branch   <= valid_i && taken;
            illegal    <= valid_i && illegal_f3;
            misaligned <= valid_i && taken && addr_bad;
            // Target is held when no branch is presented.
            if (valid_i) begin
                target <= sum;
            end
        end
    end

endmodule

// File: tb/tb_branch.sv
// Self-checking bench for branch: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        z_branch;
    logic [31:0] target;
    logic        valid_o;
    logic        illegal;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    // Expected outputs derived from the behavioural model.
    logic        exp_z;
    logic [31:0] exp_t;
    logic        exp_v;
    logic        exp_ill;
    logic        exp_mis;

    branch #(.XLEN(32), .IALIGN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .funct3     (funct3),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .pc         (pc),
        .imm        (imm),
        .z_branch   (z_branch),
        .target     (target),
        .valid_o    (valid_o),
        .illegal    (illegal),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint as_signed(input logic [31:0] v);
        longint u;
        u = longint'(v);
        return (u >= 64'sd2147483648) ? u - 64'sd4294967296 : u;
    endfunction

    function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub;
        ua = longint'(a);
        ub = longint'(b);
        case (f3)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return as_signed(a) < as_signed(b);
            3'd5:    return as_signed(a) >= as_signed(b);
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // Present one instruction, let one rising edge sample it, update the model, sample 1 time unit later.
    task automatic step(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i);
        bit tk;
        longint sum;
        valid_i  = v;
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        pc       = p;
        imm      = i;
        @(posedge clk);
        #1;
        tk = model_taken(f3, a, b);
        exp_v = v;
        if (v) begin
            sum     = (longint'(p) + longint'(i)) % 64'sd4294967296;
            exp_t   = sum[31:0];
            exp_z   = tk;
            exp_ill = (f3 == 3'd2) || (f3 == 3'd3);
            exp_mis = tk && ((sum % 4) != 0);
        end else begin
            exp_z   = 1'b0;
            exp_ill = 1'b0;
            exp_mis = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) begin
            valid_i  = 1'b1;
            funct3   = 3'($urandom);
            rs1_data = $urandom;
            rs2_data = $urandom;
            pc       = $urandom;
            imm      = $urandom;
            @(posedge clk);
            #1;
        end
        total += 5;
        if (z_branch !== 1'b0)   begin bad++; $display("FAIL reset_z got=%b exp=0", z_branch); end
        if (target !== 32'h0)    begin bad++; $display("FAIL reset_target got=%h exp=0", target); end
        if (valid_o !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        if (illegal !== 1'b0)    begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", misaligned); end
        rst_n = 1'b1;
        exp_t = 32'h0;
        step(1'b1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h8);
        total += 2;
        if (z_branch !== 1'b1) begin bad++; $display("FAIL post_reset_beq got=%b exp=1", z_branch); end
        if (valid_o !== 1'b1)  begin bad++; $display("FAIL post_reset_valid got=%b exp=1", valid_o); end
    endtask

    task automatic test_equality;
        logic [2:0]  f3s [4] = '{3'd0, 3'd0, 3'd1, 3'd1};
        logic [31:0] bs  [4] = '{32'h10, 32'h11, 32'h11, 32'h10};
        logic        zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, f3s[k], 32'h10, bs[k], 32'h2000, 32'h10);
            total++;
            if (z_branch !== zs[k]) begin
                bad++;
                $display("FAIL equality[%0d] f3=%0d got=%b exp=%b", k, f3s[k], z_branch, zs[k]);
            end
        end
    endtask

    task automatic test_signed_unsigned;
        logic [2:0] f3s [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, f3s[k], 32'hFFFF_FFFF, 32'h1, 32'h3000, 32'h20);
            total++;
            if (z_branch !== zs[k]) begin
                bad++;
                $display("FAIL sign_cmp[%0d] f3=%0d got=%b exp=%b", k, f3s[k], z_branch, zs[k]);
            end
        end
    endtask

    task automatic test_equal_operands;
        logic [2:0] f3s [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
        logic       zs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, f3s[k], 32'd7, 32'd7, 32'h4000, 32'h4);
            total++;
            if (z_branch !== zs[k]) begin
                bad++;
                $display("FAIL equal_ops[%0d] f3=%0d got=%b exp=%b", k, f3s[k], z_branch, zs[k]);
            end
        end
        step(1'b1, 3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4000, 32'h4);
        total++;
        if (z_branch !== 1'b1) begin bad++; $display("FAIL blt_minint got=%b exp=1", z_branch); end
    endtask

    task automatic test_illegal;
        logic [31:0] held;
        for (int k = 2; k < 4; k++) begin
            step(1'b1, 3'(k), 32'h10, 32'h10, 32'h5000, 32'h40);
            total += 2;
            if (z_branch !== 1'b0) begin bad++; $display("FAIL illegal_z f3=%0d got=%b exp=0", k, z_branch); end
            if (illegal !== 1'b1)  begin bad++; $display("FAIL illegal_flag f3=%0d got=%b exp=1", k, illegal); end
        end
        held = exp_t;
        for (int k = 2; k < 4; k++) begin
            step(1'b0, 3'(k), 32'h10, 32'h10, 32'h6000, 32'h80);
            total += 3;
            if (illegal !== 1'b0) begin bad++; $display("FAIL idle_illegal f3=%0d got=%b exp=0", k, illegal); end
            if (valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid f3=%0d got=%b exp=0", k, valid_o); end
            if (target !== held)  begin bad++; $display("FAIL idle_target_hold got=%h exp=%h", target, held); end
        end
    endtask

    task automatic test_target;
        step(1'b1, 3'd1, 32'h1, 32'h1, 32'h0000_1000, 32'hFFFF_FFF8);
        total++;
        if (target !== 32'h0000_0FF8) begin bad++; $display("FAIL target_neg got=%h exp=00000ff8", target); end
        step(1'b1, 3'd1, 32'h1, 32'h1, 32'hFFFF_FFFC, 32'h8);
        total++;
        if (target !== 32'h0000_0004) begin bad++; $display("FAIL target_wrap got=%h exp=00000004", target); end
        step(1'b1, 3'd0, 32'h3, 32'h3, 32'h0000_1000, 32'h6);
        total += 3;
        if (target !== 32'h0000_1006) begin bad++; $display("FAIL target_mis got=%h exp=00001006", target); end
        if (misaligned !== 1'b1)      begin bad++; $display("FAIL mis_taken got=%b exp=1", misaligned); end
        if (z_branch !== 1'b1)        begin bad++; $display("FAIL mis_z got=%b exp=1", z_branch); end
        step(1'b1, 3'd1, 32'h3, 32'h3, 32'h0000_1000, 32'h6);
        total++;
        if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_not_taken got=%b exp=0", misaligned); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b, i;
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            // Bias toward equal and near-equal operands so every condition sees both outcomes.
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a + 32'($urandom_range(0, 2)) - 32'd1;
                2:       b = {~a[31], a[30:0]};
                default: b = $urandom;
            endcase
            i = $urandom_range(0, 1) ? {$urandom} & 32'hFFFF_FFFE : 32'($urandom_range(0, 15)) << 1;
            step(1'($urandom_range(0, 4) != 0), 3'($urandom), a, b, $urandom, i);
            total++;
            if ({z_branch, target, valid_o, illegal, misaligned} !== {exp_z, exp_t, exp_v, exp_ill, exp_mis}) begin
                bad++;
                $display("FAIL random[%0d] got z=%b t=%h v=%b ill=%b mis=%b exp z=%b t=%h v=%b ill=%b mis=%b",
                         n, z_branch, target, valid_o, illegal, misaligned,
                         exp_z, exp_t, exp_v, exp_ill, exp_mis);
            end
        end
    endtask

    task automatic test_midstream_reset;
        step(1'b1, 3'd0, 32'h9, 32'h9, 32'h7000, 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({z_branch, target, valid_o, illegal, misaligned} !== '0) begin
            bad++;
            $display("FAIL midstream_reset got z=%b t=%h v=%b ill=%b mis=%b exp all 0",
                     z_branch, target, valid_o, illegal, misaligned);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_t = 32'h0;
        step(1'b1, 3'd7, 32'h2, 32'h1, 32'h100, 32'h20);
        total += 2;
        if (z_branch !== 1'b1)     begin bad++; $display("FAIL after_reset_bgeu got=%b exp=1", z_branch); end
        if (target !== 32'h120)    begin bad++; $display("FAIL after_reset_target got=%h exp=00000120", target); end
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        funct3   = 3'd0;
        rs1_data = '0;
        rs2_data = '0;
        pc       = '0;
        imm      = '0;
        exp_z    = 1'b0;
        exp_t    = '0;
        exp_v    = 1'b0;
        exp_ill  = 1'b0;
        exp_mis  = 1'b0;
        test_reset();
        test_equality();
        test_signed_unsigned();
        test_equal_operands();
        test_illegal();
        test_target();
        test_back_to_back();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
